// File: rtl/addr_share_arb_pkg.sv
// Shared types and sizing helpers for the shared add/subtract arbiter.
// Holds the sequencer state encoding and the round-robin pointer width rule.
// No ports; imported by addr_share_arb and available to rr_pick users.
package addr_share_arb_pkg;

  // Sequencer states: sample a request, execute it, present the result.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } arb_state_t;

  // Pointer width for the default 4-requester build.
  localparam int unsigned ARB_NREQ_DEF = 4;
  localparam int unsigned ARB_PTR_W    = $clog2(ARB_NREQ_DEF);

  // Pointer width for an arbitrary requester count; never narrower than 1 bit.
  function automatic int unsigned arb_ptr_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/addr_share_arb_rr_pick.sv
// Round-robin picker: first set bit of elig_i at or above ptr_i, wrapping.
// Purely combinational, zero latency.
// Ports: elig_i (eligible vector), ptr_i (search start), pick_o (one-hot), found_o.
module rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned PW = 2
) (
  input  logic [N-1:0]  elig_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  pick_o,
  output logic          found_o
);

  logic [2*N-1:0] dbl_rot;
  logic [N-1:0]   rot;
  logic [N-1:0]   lowest;
  logic [2*N-1:0] dbl_back;

  // Rotate the request vector so that bit ptr lands at position 0, take the
  // lowest set bit with the two's complement trick, then rotate back.
  always_comb begin
    dbl_rot  = {elig_i, elig_i} >> ptr_i;
    rot      = dbl_rot[N-1:0];
    lowest   = rot & (~rot + {{(N-1){1'b0}}, 1'b1});
    dbl_back = {lowest, lowest} << ptr_i;
    pick_o   = dbl_back[2*N-1:N];
    found_o  = |elig_i;
  end

endmodule

// File: rtl/addr_share_arb.sv
// Round-robin sequencer sharing one registered WIDTH-bit add/subtract unit among NREQ clients.
// Ports: arb_c1/arb_rstn_i1 clock and sync active-low reset; per-requester req/mask/sub/a/b in;
// one-hot gnt and vld pulses, shared res/cout, busy flag and saturating ops counter out.
module addr_share_arb
  import addr_share_arb_pkg::*;
#(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNTW  = 16
) (
  input  logic                  arb_c1,
  input  logic                  arb_rstn_i1,
  input  logic [NREQ-1:0]       arb_req_i1,
  input  logic [NREQ-1:0]       arb_mask_i1,
  input  logic [NREQ-1:0]       arb_sub_i1,
  input  logic [NREQ*WIDTH-1:0] arb_a_i1,
  input  logic [NREQ*WIDTH-1:0] arb_b_i1,
  output logic [NREQ-1:0]       arb_gnt_o1,
  output logic [NREQ-1:0]       arb_vld_o1,
  output logic [WIDTH-1:0]      arb_res_o1,
  output logic                  arb_cout_o1,
  output logic                  arb_busy_o1,
  output logic [CNTW-1:0]       arb_ops_o1
);

  localparam int unsigned PTR_W = arb_ptr_w(NREQ);

  arb_state_t       state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [NREQ-1:0]  sel_q, sel_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             sub_q, sub_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [NREQ-1:0]  vld_q, vld_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             cout_q, cout_d;
  logic [CNTW-1:0]  ops_q, ops_d;

  logic [NREQ-1:0]  elig;
  logic [NREQ-1:0]  pick;
  logic             found;
  logic [WIDTH-1:0] a_mux, b_mux;
  logic             sub_mux;
  logic [PTR_W-1:0] ptr_nxt;
  logic [WIDTH:0]   sum;

  assign elig = arb_req_i1 & arb_mask_i1;

  rr_pick #(
    .N  (NREQ),
    .PW (PTR_W)
  ) u_rr_pick (
    .elig_i  (elig),
    .ptr_i   (ptr_q),
    .pick_o  (pick),
    .found_o (found)
  );

  // AND-OR operand mux driven by the one-hot pick; also derives the pointer
  // value one past the winner.
  always_comb begin
    a_mux   = '0;
    b_mux   = '0;
    sub_mux = 1'b0;
    ptr_nxt = '0;
    for (int k = 0; k < int'(NREQ); k++) begin
      a_mux   = a_mux | (arb_a_i1[k*WIDTH +: WIDTH] & {WIDTH{pick[k]}});
      b_mux   = b_mux | (arb_b_i1[k*WIDTH +: WIDTH] & {WIDTH{pick[k]}});
      sub_mux = sub_mux | (arb_sub_i1[k] & pick[k]);
      if (pick[k]) begin
        ptr_nxt = PTR_W'((k + 1) % int'(NREQ));
      end
    end
  end

  // Subtract is a + ~b + 1; the carry out then reads as "no borrow".
  assign sum = {1'b0, a_q} + {1'b0, b_q ^ {WIDTH{sub_q}}} + {{WIDTH{1'b0}}, sub_q};

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    a_d     = a_q;
    b_d     = b_q;
    sub_d   = sub_q;
    gnt_d   = '0;
    vld_d   = '0;
    res_d   = res_q;
    cout_d  = cout_q;
    ops_d   = ops_q;
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          a_d     = a_mux;
          b_d     = b_mux;
          sub_d   = sub_mux;
          sel_d   = pick;
          gnt_d   = pick;
          ptr_d   = ptr_nxt;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        {cout_d, res_d} = sum;
        vld_d           = sel_q;
        state_d         = ST_RESP;
      end
      ST_RESP: begin
        if (ops_q != {CNTW{1'b1}}) begin
          ops_d = ops_q + CNTW'(1);
        end
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge arb_c1) begin
    if (!arb_rstn_i1) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      vld_q   <= '0;
      res_q   <= '0;
      cout_q  <= 1'b0;
      ops_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      vld_q   <= vld_d;
      res_q   <= res_d;
      cout_q  <= cout_d;
      ops_q   <= ops_d;
    end
  end

  // Operand latch and winner record are only read after being loaded in
  // IDLE, so they carry no reset.
  always_ff @(posedge arb_c1) begin
    sel_q <= sel_d;
    a_q   <= a_d;
    b_q   <= b_d;
    sub_q <= sub_d;
  end

  assign arb_gnt_o1  = gnt_q;
  assign arb_vld_o1  = vld_q;
  assign arb_res_o1  = res_q;
  assign arb_cout_o1 = cout_q;
  assign arb_busy_o1 = (state_q != ST_IDLE);
  assign arb_ops_o1  = ops_q;

endmodule
